// File: rtl/conv3x3_pkg.sv
// Shared definitions for the 3x3 convolution block.
//   - FSM state encoding
//   - pixel/weight width, product width, accumulator width
//   - 16-bit saturation limits and a saturation helper
package conv3x3_pkg;

  localparam int PIX_W  = 16;
  localparam int PROD_W = 2 * PIX_W;
  localparam int ACC_W  = 36;
  localparam int NTAPS  = 9;

  localparam logic [PIX_W-1:0]        SAT_MAX     = 16'h7FFF;
  localparam logic [PIX_W-1:0]        SAT_MIN     = 16'h8000;
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = -36'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Clamp a wide signed value into the signed 16-bit output range.
  function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [PIX_W-1:0] r;
    if (v > ACC_SAT_MAX)      r = SAT_MAX;
    else if (v < ACC_SAT_MIN) r = SAT_MIN;
    else                      r = v[PIX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// Two-stage multiply-accumulate for one 3x3 window.
//   Stage 1: nine registered 16x16 signed products (32 bit) plus valid,
//            last-of-frame flag and output coordinates.
//   Stage 2: 36-bit sum, arithmetic shift right by FRAC (floor),
//            saturation to 16 bits; result registers hold when idle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   valid_i, last_i       a window completes this cycle / it is the frame's last
//   row_i, col_i          output coordinates of that window
//   win_i, wgt_i          nine window pixels and nine weights, row-major
//   out_valid, out_data   result strobe and saturated result
//   out_row, out_col      result coordinates
//   done                  pulses with the frame's last result
module conv3x3_mac
  import conv3x3_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic                        last_i,
  input  logic [7:0]                  row_i,
  input  logic [7:0]                  col_i,
  input  logic [NTAPS-1:0][PIX_W-1:0] win_i,
  input  logic [NTAPS-1:0][PIX_W-1:0] wgt_i,
  output logic                        out_valid,
  output logic [PIX_W-1:0]            out_data,
  output logic [7:0]                  out_row,
  output logic [7:0]                  out_col,
  output logic                        done
);

  logic [NTAPS-1:0][PROD_W-1:0] prod_q, prod_d;
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_last_q, s1_last_d;
  logic [7:0]                   s1_row_q, s1_row_d;
  logic [7:0]                   s1_col_q, s1_col_d;

  logic                         out_valid_q, out_valid_d;
  logic [PIX_W-1:0]             out_data_q, out_data_d;
  logic [7:0]                   out_row_q, out_row_d;
  logic [7:0]                   out_col_q, out_col_d;
  logic                         done_q, done_d;

  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      shifted;

  // Stage 1: operands are sign-extended to 32 bits so the low 32 bits
  // of the product are the exact signed result.
  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = valid_i;
    s1_last_d  = s1_last_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    if (valid_i) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod_d[k] = $signed({{PIX_W{win_i[k][PIX_W-1]}}, win_i[k]}) *
                    $signed({{PIX_W{wgt_i[k][PIX_W-1]}}, wgt_i[k]});
      end
      s1_last_d = last_i;
      s1_row_d  = row_i;
      s1_col_d  = col_i;
    end
  end

  // Stage 2
  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum = sum + $signed({{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]});
    end
    shifted     = sum >>> FRAC;
    out_valid_d = s1_valid_q;
    done_d      = s1_valid_q && s1_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (s1_valid_q) begin
      out_data_d = saturate(shifted);
      out_row_d  = s1_row_q;
      out_col_d  = s1_col_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign done      = done_q;

endmodule

// File: rtl/conv3x3.sv
// 3x3 signed Q-format convolution over a streamed SIZE x SIZE image.
// Each in_valid cycle delivers one image column (three vertically adjacent
// pixels). The block keeps the weights, the 3x3 window, the column/row
// counters and the FSM; conv3x3_mac does the arithmetic.
// Handshake: in_valid is a one-cycle qualifier with no back-pressure; the
// column is consumed on every clock edge where in_valid is high. out_valid
// qualifies out_data/out_row/out_col for exactly one cycle each, two cycles
// after the completing column; there is no ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   w_load, w_addr, w_data     weight write (addresses 9..15 ignored)
//   in_valid, in_top/mid/bot   column input, rows r, r+1, r+2
//   out_valid, out_data        convolution result
//   out_row, out_col           result coordinates 0..SIZE-3
//   done                       pulses with the frame's last result
module conv3x3
  import conv3x3_pkg::*;
#(
  parameter int SIZE = 14,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_load,
  input  logic [3:0]       w_addr,
  input  logic [PIX_W-1:0] w_data,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_top,
  input  logic [PIX_W-1:0] in_mid,
  input  logic [PIX_W-1:0] in_bot,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic [7:0]       out_row,
  output logic [7:0]       out_col,
  output logic             done
);

  state_t                       state_q, state_d;
  logic [7:0]                   col_q, col_d;
  logic [7:0]                   row_q, row_d;
  logic [NTAPS-1:0][PIX_W-1:0]  wgt_q, wgt_d;
  logic [NTAPS-1:0][PIX_W-1:0]  win_q, win_d;
  logic [2:0][PIX_W-1:0]        col_px;
  logic                         last_col, last_row;
  logic                         win_valid, win_last;
  logic [7:0]                   win_col;

  assign col_px = {in_bot, in_mid, in_top};

  always_comb begin
    wgt_d = wgt_q;
    if (w_load && (w_addr < 4'd9)) wgt_d[w_addr] = w_data;
  end

  // Window is row-major: index 3*r + c, c = 0 is the oldest column.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
        win_d[3*r + 2] = col_px[r];
      end
    end
  end

  always_comb begin
    last_col = (col_q == 8'(SIZE-1));
    last_row = (row_q == 8'(SIZE-3));
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? 8'd0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (col_q == 8'd1) state_d = ST_RUN;
        ST_RUN:  if (last_col) state_d = last_row ? ST_IDLE : ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
    // In RUN the accepted column has index >= 2, so it closes a window.
    win_valid = in_valid && (state_q == ST_RUN);
    win_last  = win_valid && last_col && last_row;
    win_col   = col_q - 8'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wgt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wgt_q   <= wgt_d;
      win_q   <= win_d;
    end
  end

  // The MAC captures the shifted-in window directly so the result lands
  // two cycles after the completing column.
  conv3x3_mac #(.FRAC(FRAC)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (win_valid),
    .last_i    (win_last),
    .row_i     (row_q),
    .col_i     (win_col),
    .win_i     (win_d),
    .wgt_i     (wgt_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

endmodule

// File: tb/tb_conv3x3.sv
// Directed testbench for conv3x3: constant, identity and saturating kernels,
// gapped input, mid-frame reset and a mid-frame weight update.
module tb_conv3x3;

  localparam int SIZE  = 14;
  localparam int EXP_W = 33;  // {done, row[7:0], col[7:0], data[15:0]}

  logic        clk;
  logic        rst_n;
  logic        w_load;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic        in_valid;
  logic [15:0] in_top, in_mid, in_bot;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_row, out_col;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frame_outs = 0;
  int frame_dones = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               cyc_q[$];
  logic [EXP_W-1:0] mon_e;
  int               mon_c;

  conv3x3 #(.SIZE(SIZE), .FRAC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_load    (w_load),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_top    (in_top),
    .in_mid    (in_mid),
    .in_bot    (in_bot),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("out_valid_unexpected", out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check_val("out_data", out_data, mon_e[15:0]);
        check_val("out_col",  out_col,  mon_e[23:16]);
        check_val("out_row",  out_row,  mon_e[31:24]);
        check_val("done",     done,     mon_e[32]);
        check_val("latency",  cyc,      mon_c);
      end
      frame_outs++;
      if (done) frame_dones++;
    end else if (rst_n && done) begin
      check_val("done_without_valid", done, out_valid);
    end
  end

  // Driver tasks
  task automatic load_weight(input int idx, input logic [15:0] v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    w_load   = 1'b1;
    w_addr   = 4'(idx);
    w_data   = v;
    @(posedge clk); #1;
    w_load   = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] v);
    for (int i = 0; i < 9; i++) load_weight(i, v);
  endtask

  // mode 0: every pixel = pv, result exp_a (exp_b after the weight switch)
  // mode 1: pixel = row*SIZE + col, result = centre pixel
  // sw_at >= 0: write w4 = 0x0200 before that column index
  // abort_at >= 0: pulse reset before that column index and return
  task automatic run_frame(input int mode, input logic [15:0] pv, input logic [15:0] exp_a,
                           input int gap, input int sw_at, input logic [15:0] exp_b,
                           input int abort_at);
    logic [15:0] e;
    logic [15:0] ev;
    logic        dn;
    int          n;
    e = exp_a;
    n = 0;
    frame_outs  = 0;
    frame_dones = 0;
    for (int r = 0; r < SIZE - 2; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (abort_at >= 0 && n == abort_at) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          exp_q.delete();
          cyc_q.delete();
          rst_n = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        if (n == sw_at) begin
          load_weight(4, 16'h0200);
          e = exp_b;
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        if (mode == 1) begin
          in_top = 16'(r * SIZE + c);
          in_mid = 16'((r + 1) * SIZE + c);
          in_bot = 16'((r + 2) * SIZE + c);
        end else begin
          in_top = pv;
          in_mid = pv;
          in_bot = pv;
        end
        if (c >= 2) begin
          ev = (mode == 1) ? 16'((r + 1) * SIZE + c - 1) : e;
          dn = (r == SIZE - 3) && (c == SIZE - 1);
          exp_q.push_back({dn, 8'(r), 8'(c - 2), ev});
          cyc_q.push_back(cyc + 2);
        end
        repeat (gap) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
        n++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("frame_outputs", frame_outs, (SIZE - 2) * (SIZE - 2));
    check_val("frame_dones", frame_dones, 1);
    check_val("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    w_load   = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    in_valid = 1'b0;
    in_top   = '0;
    in_mid   = '0;
    in_bot   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data",  out_data,  16'h0000);
    check_val("rst_out_row",   out_row,   8'h00);
    check_val("rst_out_col",   out_col,   8'h00);
    check_val("rst_done",      done,      1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Uniform 1.0 kernel and image; writes to addresses 9 and 15 are ignored.
    load_all(16'h0100);
    load_weight(9, 16'h7FFF);
    load_weight(15, 16'h8000);
    run_frame(0, 16'h0100, 16'h0900, 0, -1, 16'h0000, -1);

    // Identity kernel
    load_all(16'h0000);
    load_weight(4, 16'h0100);
    run_frame(1, 16'h0000, 16'h0000, 0, -1, 16'h0000, -1);

    // Positive and negative saturation
    load_all(16'h7FFF);
    run_frame(0, 16'h7FFF, 16'h7FFF, 0, -1, 16'h0000, -1);
    load_all(16'h8000);
    run_frame(0, 16'h7FFF, 16'h8000, 0, -1, 16'h0000, -1);

    // 1-on / 2-off input
    load_all(16'h0100);
    run_frame(0, 16'h0100, 16'h0900, 2, -1, 16'h0000, -1);

    // Reset after 50 columns, then a clean frame
    run_frame(0, 16'h0100, 16'h0900, 0, -1, 16'h0000, 50);
    @(negedge clk);
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_out_data",  out_data,  16'h0000);
    check_val("midrst_done",      done,      1'b0);
    repeat (4) @(posedge clk);
    load_all(16'h0100);
    run_frame(0, 16'h0100, 16'h0900, 0, -1, 16'h0000, -1);

    // Centre weight raised to 2.0 mid-frame
    run_frame(0, 16'h0100, 16'h0900, 0, 80, 16'h0A00, -1);

    repeat (4) @(posedge clk);
    check_val("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
